// File: rtl/flappy_player.sv
// flappy_player: compositor and game-logic stage after the scrolling background.
// Overlays an 8x8 player sprite on the background pixel stream, runs per-frame
// flap/gravity physics, detects sprite-vs-terrain collisions and keeps a score.
//
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   hpos, vpos          current pixel position
//   display_on          active-video flag
//   hsync_in, vsync_in  raw syncs
//   bg_rgb, bg_solid    background colour and terrain mask (same cycle)
//   flap                asynchronous button
//   rgb                 composited colour, registered (1-cycle latency)
//   hsync, vsync        syncs delayed by one cycle to match rgb
//   crashed             high while in the crashed state
//   score               saturating flight score
module flappy_player #(
  parameter int unsigned BIRD_X       = 64,
  parameter int unsigned START_Y      = 120,
  parameter int          FLAP_VEL     = -6,
  parameter int          GRAVITY      = 1,
  parameter int          MAX_FALL     = 7,
  parameter int unsigned FLOOR_Y      = 248,
  parameter int unsigned FRAME_LINE   = 480,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned SCORE_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] bg_rgb,
  input  logic       bg_solid,
  input  logic       flap,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       crashed,
  output logic [7:0] score
);

  localparam int unsigned ScW = $clog2(SCORE_FRAMES + 1);
  localparam int unsigned CrW = $clog2(CRASH_FRAMES + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFlying  = 2'd1;
  localparam logic [1:0] StCrashed = 2'd2;

  localparam logic [9:0]        BirdX     = 10'(BIRD_X);
  localparam logic [7:0]        StartY    = 8'(START_Y);
  localparam logic [7:0]        FloorY    = 8'(FLOOR_Y);
  localparam logic signed [9:0] FloorYS   = 10'(FLOOR_Y);
  localparam logic [9:0]        FrameLine = 10'(FRAME_LINE);
  localparam logic signed [5:0] FlapVel   = 6'(FLAP_VEL);
  localparam logic signed [5:0] MaxFall   = 6'(MAX_FALL);
  localparam logic signed [6:0] MaxFall7  = 7'(MAX_FALL);
  localparam logic signed [6:0] Gravity7  = 7'(GRAVITY);
  localparam logic [ScW-1:0]    ScoreLast = ScW'(SCORE_FRAMES - 1);
  localparam logic [CrW-1:0]    CrashLast = CrW'(CRASH_FRAMES - 1);

  function automatic logic [7:0] sprite_row(input logic [2:0] r);
    logic [7:0] row;
    case (r)
      3'd0:    row = 8'h3C;
      3'd1:    row = 8'h7E;
      3'd2:    row = 8'hFF;
      3'd3:    row = 8'hDB;
      3'd4:    row = 8'hFF;
      3'd5:    row = 8'h7E;
      3'd6:    row = 8'h3C;
      default: row = 8'h18;
    endcase
    return row;
  endfunction

  // State
  logic [1:0]        state_q, state_d;
  logic [7:0]        bird_y_q, bird_y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [7:0]        score_q, score_d;
  logic [ScW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CrW-1:0]    crash_cnt_q, crash_cnt_d;
  logic              hit_q, hit_d;
  logic              pending_q, pending_d;
  logic [2:0]        sync_q;  // [0],[1] synchronizer, [2] previous for edge detect
  logic [2:0]        rgb_q, rgb_d;
  logic              hsync_q, vsync_q;

  logic frame_tick;
  assign frame_tick = (hpos == 10'd0) && (vpos == FrameLine);

  logic flap_edge;
  assign flap_edge = sync_q[1] & ~sync_q[2];

  // Sprite hit test; the subtractions wrap when outside, so bounds are checked too
  logic [9:0] dx, dy;
  logic       in_x, in_y, opaque;
  logic [7:0] row_bits;
  assign dx       = hpos - BirdX;
  assign dy       = vpos - {2'b00, bird_y_q};
  assign in_x     = (hpos >= BirdX) && (dx < 10'd8);
  assign in_y     = (vpos >= {2'b00, bird_y_q}) && (dy < 10'd8);
  assign row_bits = sprite_row(dy[2:0]);
  assign opaque   = in_x && in_y && row_bits[3'd7 - dx[2:0]] && display_on;

  logic [2:0] sprite_col;
  assign sprite_col = (state_q == StCrashed) ? 3'b100 : 3'b110;

  // Includes a hit written on the tick cycle itself, before the clear
  logic hit_now, hit_eff;
  assign hit_now = opaque & bg_solid;
  assign hit_eff = hit_q | hit_now;

  always_comb begin
    rgb_d     = opaque ? sprite_col : (display_on ? bg_rgb : 3'b000);
    hit_d     = frame_tick ? 1'b0 : hit_eff;
    pending_d = frame_tick ? 1'b0 : (pending_q | flap_edge);
  end

  // Physics
  logic signed [9:0] ny;
  logic signed [6:0] vel_inc;
  assign ny      = $signed({2'b00, bird_y_q}) + $signed({{4{vel_q[5]}}, vel_q});
  assign vel_inc = $signed({vel_q[5], vel_q}) + Gravity7;

  always_comb begin
    state_d     = state_q;
    bird_y_d    = bird_y_q;
    vel_d       = vel_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    crash_cnt_d = crash_cnt_q;
    if (frame_tick) begin
      case (state_q)
        StIdle: begin
          bird_y_d = StartY;
          vel_d    = '0;
          if (pending_q) begin
            state_d     = StFlying;
            vel_d       = FlapVel;
            score_d     = '0;
            frame_cnt_d = '0;
          end
        end
        StFlying: begin
          if (frame_cnt_q == ScoreLast) begin
            frame_cnt_d = '0;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          if (hit_eff) begin
            state_d     = StCrashed;
            crash_cnt_d = '0;
          end else if (ny >= FloorYS) begin
            state_d     = StCrashed;
            bird_y_d    = FloorY;
            crash_cnt_d = '0;
          end else begin
            bird_y_d = ny[9] ? 8'd0 : ny[7:0];
            if (pending_q)                vel_d = FlapVel;
            else if (vel_inc > MaxFall7)  vel_d = MaxFall;
            else                          vel_d = vel_inc[5:0];
          end
        end
        StCrashed: begin
          if (crash_cnt_q == CrashLast) begin
            state_d     = StIdle;
            bird_y_d    = StartY;
            vel_d       = '0;
            crash_cnt_d = '0;
          end else begin
            crash_cnt_d = crash_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = StIdle;
          bird_y_d = StartY;
          vel_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bird_y_q    <= StartY;
      vel_q       <= '0;
      score_q     <= '0;
      frame_cnt_q <= '0;
      crash_cnt_q <= '0;
      hit_q       <= 1'b0;
      pending_q   <= 1'b0;
      sync_q      <= '0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bird_y_q    <= bird_y_d;
      vel_q       <= vel_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      crash_cnt_q <= crash_cnt_d;
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      sync_q      <= {sync_q[1:0], flap};
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
    end
  end

  assign rgb     = rgb_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign crashed = (state_q == StCrashed);
  assign score   = score_q;

endmodule

// File: tb/tb_flappy_player.sv
// Self-checking bench for flappy_player. Pixel positions are driven directly so
// a "frame" is only a handful of cycles ending in the frame-tick cycle.
module tb_flappy_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = '0, vpos = '0;
  logic       display_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [2:0] bg_rgb = '0;
  logic       bg_solid = 1'b0, flap = 1'b0;
  logic [2:0] rgb;
  logic       hsync, vsync, crashed;
  logic [7:0] score;

  always #5 clk = ~clk;

  flappy_player dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .bg_rgb     (bg_rgb),
    .bg_solid   (bg_solid),
    .flap       (flap),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .crashed    (crashed),
    .score      (score)
  );

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       d;
    logic [2:0] bg;
    logic [2:0] exp;
  } vec_t;
  vec_t vt[16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel cycle: expectation is queued with the stimulus, compared after the edge
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic d,
                     input logic [2:0] bg, input logic s, input logic [2:0] exp,
                     input string name);
    exp_t e, got;
    hpos = h; vpos = v; display_on = d; bg_rgb = bg; bg_solid = s;
    hsync_in = cyc[0]; vsync_in = cyc[2]; cyc++;
    e.rgb = reset ? 3'b000 : exp;
    e.hs  = reset ? 1'b0 : hsync_in;
    e.vs  = reset ? 1'b0 : vsync_in;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    check(name, int'({rgb, hsync, vsync}), int'({got.rgb, got.hs, got.vs}));
  endtask

  task automatic idle();
    pix(10'd0, 10'd0, 1'b0, 3'b111, 1'b0, 3'b000, "idle");
  endtask

  task automatic tick();
    pix(10'd0, 10'd480, 1'b0, 3'b000, 1'b0, 3'b000, "tick");
  endtask

  task automatic noflap_frame();
    idle();
    tick();
  endtask

  // Flap edge lands in flap_pending before the tick of this frame
  task automatic flap_frame();
    flap = 1'b1; idle(); idle();
    flap = 1'b0; idle(); idle();
    tick();
  endtask

  // Row 0 of the sprite is opaque at column BIRD_X+2; the row above is background
  task automatic probe(input int y, input logic [2:0] col, input string name);
    pix(10'd66, 10'(y), 1'b1, 3'b001, 1'b0, col, name);
    if (y > 0) pix(10'd66, 10'(y - 1), 1'b1, 3'b001, 1'b0, 3'b001, {name, " above"});
  endtask

  initial begin
    int m_y, m_vel, ny, fly_ticks;
    bit crash_seen;

    vt[0]  = '{10'd66, 10'd120, 1'b1, 3'b011, 3'b110};
    vt[1]  = '{10'd64, 10'd120, 1'b1, 3'b011, 3'b011};
    vt[2]  = '{10'd65, 10'd120, 1'b1, 3'b011, 3'b011};
    vt[3]  = '{10'd67, 10'd121, 1'b1, 3'b010, 3'b110};
    vt[4]  = '{10'd64, 10'd121, 1'b1, 3'b010, 3'b010};
    vt[5]  = '{10'd64, 10'd122, 1'b1, 3'b010, 3'b110};
    vt[6]  = '{10'd71, 10'd122, 1'b1, 3'b101, 3'b110};
    vt[7]  = '{10'd72, 10'd122, 1'b1, 3'b101, 3'b101};
    vt[8]  = '{10'd63, 10'd122, 1'b1, 3'b101, 3'b101};
    vt[9]  = '{10'd66, 10'd123, 1'b1, 3'b001, 3'b001};
    vt[10] = '{10'd67, 10'd127, 1'b1, 3'b001, 3'b110};
    vt[11] = '{10'd66, 10'd127, 1'b1, 3'b111, 3'b111};
    vt[12] = '{10'd67, 10'd128, 1'b1, 3'b111, 3'b111};
    vt[13] = '{10'd66, 10'd119, 1'b1, 3'b111, 3'b111};
    vt[14] = '{10'd66, 10'd120, 1'b0, 3'b111, 3'b000};
    vt[15] = '{10'd10, 10'd10,  1'b0, 3'b111, 3'b000};

    // Reset with live-looking inputs: outputs must stay zero
    reset = 1'b1;
    pix(10'd66, 10'd120, 1'b1, 3'b111, 1'b1, 3'b110, "reset");
    pix(10'd66, 10'd120, 1'b1, 3'b111, 1'b1, 3'b110, "reset");
    reset = 1'b0;
    check("reset crashed", int'(crashed), 0);
    check("reset score", int'(score), 0);

    // Three frames without a flap stay idle
    for (int i = 0; i < 3; i++) noflap_frame();
    check("idle crashed", int'(crashed), 0);
    check("idle score", int'(score), 0);
    foreach (vt[i]) pix(vt[i].h, vt[i].v, vt[i].d, vt[i].bg, 1'b0, vt[i].exp, $sformatf("vec%0d", i));

    // Start, then free fall until the floor
    flap_frame();
    probe(120, 3'b110, "start y");
    m_y = 120; m_vel = -6; fly_ticks = 0; crash_seen = 0;
    for (int k = 0; k < 100 && !crash_seen; k++) begin
      noflap_frame();
      fly_ticks++;
      ny = m_y + m_vel;
      if (ny >= 248) begin
        m_y = 248; crash_seen = 1;
      end else begin
        m_y   = (ny < 0) ? 0 : ny;
        m_vel = (m_vel + 1 > 7) ? 7 : m_vel + 1;
      end
      probe(m_y, crash_seen ? 3'b100 : 3'b110, $sformatf("fall y=%0d", m_y));
      check("fall crashed", int'(crashed), int'(crash_seen));
    end
    check("floor crashed", int'(crashed), 1);
    check("fall score", int'(score), fly_ticks / 32);

    // Crashed for 60 ticks; flaps during this time are ignored
    for (int i = 0; i < 59; i++) begin
      if (i < 5) flap_frame(); else noflap_frame();
    end
    check("crash hold", int'(crashed), 1);
    probe(248, 3'b100, "crash y");
    noflap_frame();
    check("crash end", int'(crashed), 0);
    probe(120, 3'b110, "back to start");
    check("score retained", int'(score), fly_ticks / 32);

    // Terrain touching only a transparent sprite pixel does not crash
    flap_frame();
    check("restart score", int'(score), 0);
    pix(10'd64, 10'd120, 1'b1, 3'b010, 1'b1, 3'b010, "solid transparent");
    noflap_frame();
    check("no crash", int'(crashed), 0);
    probe(114, 3'b110, "after miss");
    pix(10'd66, 10'd114, 1'b1, 3'b010, 1'b1, 3'b110, "solid opaque");
    noflap_frame();
    check("hit crash", int'(crashed), 1);
    probe(114, 3'b100, "hit y held");
    for (int i = 0; i < 60; i++) noflap_frame();
    check("hit recover", int'(crashed), 0);

    // Flap every frame: clamp at the top and saturate the score
    flap_frame();
    for (int i = 1; i <= 8200; i++) begin
      flap_frame();
      if (i == 25) begin
        probe(0, 3'b110, "top clamp");
        check("top no crash", int'(crashed), 0);
      end
      if (i == 31)   check("score before 32", int'(score), 0);
      if (i == 32)   check("score at 32", int'(score), 1);
      if (i == 8159) check("score 254", int'(score), 254);
      if (i == 8160) check("score 255", int'(score), 255);
    end
    check("score sat", int'(score), 255);
    check("sat no crash", int'(crashed), 0);

    // Reset mid-flight
    reset = 1'b1;
    pix(10'd66, 10'd0, 1'b1, 3'b001, 1'b0, 3'b110, "midflight reset");
    reset = 1'b0;
    check("mid reset score", int'(score), 0);
    check("mid reset crashed", int'(crashed), 0);
    probe(120, 3'b110, "mid reset y");
    noflap_frame();
    check("post reset idle", int'(score), 0);
    probe(120, 3'b110, "post reset y");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flappy_player.md
# flappy_player

Downstream compositor and game-logic stage for the scrolling space background. It draws an 8x8 player sprite over the background pixel stream, runs per-frame flap and gravity physics, and detects collisions against the terrain mask. It keeps a flight score and delays the sync signals so they stay aligned with its registered RGB output.

## Interface
Parameters:
- BIRD_X, 64: sprite left column, fixed.
- START_Y, 120: sprite top row while in IDLE.
- FLAP_VEL, -6: signed velocity loaded on a flap.
- GRAVITY, 1: velocity increment per frame.
- MAX_FALL, 7: velocity ceiling.
- FLOOR_Y, 248: top-row value that counts as a crash.
- FRAME_LINE, 480: vpos of the frame tick, which falls outside the visible area.
- CRASH_FRAMES, 60: frames spent in CRASHED.
- SCORE_FRAMES, 32: flying frames per score point.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- hpos, vpos  in  10 each  current pixel position from the sync generator.
- display_on  in  1  active-video flag.
- hsync_in, vsync_in  in  1 each  raw syncs.
- bg_rgb  in  3  background colour.
- bg_solid  in  1  terrain mask, aligned with bg_rgb; set where the mountain layers are drawn.
- flap  in  1  button, asynchronous.
- rgb  out  3  composited colour, registered.
- hsync, vsync  out  1 each  syncs delayed by 1 cycle.
- crashed  out  1  high while in CRASHED.
- score  out  8  saturating score.

## Operation
- frame_tick = (hpos==0 && vpos==FRAME_LINE). It lasts one cycle per frame. All physics and state changes happen only on the tick.
- Flap input path:
  - two-flop synchronizer, then rising-edge detect;
  - the edge sets flap_pending;
  - flap_pending clears on every tick, whether it is consumed or not.
- State: bird_y (unsigned 8-bit) and vel (signed 6-bit).
- Sprite ROM, rows 0..7: 3C 7E FF DB FF 7E 3C 18. Bit 7 is the leftmost column.
- A sprite pixel is opaque when:
  - hpos is in BIRD_X..BIRD_X+7;
  - vpos is in bird_y..bird_y+7;
  - ROM[vpos-bird_y] bit (7-(hpos-BIRD_X)) is 1;
  - display_on is high.
- Sprite colour is 3'b110 in IDLE and FLYING, and 3'b100 in CRASHED.
- Compositing: rgb = opaque ? sprite colour : (display_on ? bg_rgb : 0).
- Collision: opaque && bg_solid sets hit_latch. hit_latch clears on each tick, after it has been sampled.
- FSM, IDLE:
  - bird_y = START_Y, vel = 0.
  - Tick with flap_pending: go to FLYING, vel = FLAP_VEL, score = 0, bird_y unchanged.
- FSM, FLYING, on each tick. Compute ny = bird_y + vel as a signed 10-bit value, then apply the first matching rule:
  1. hit_latch set: go to CRASHED; bird_y and vel hold.
  2. ny >= FLOOR_Y: go to CRASHED, bird_y = FLOOR_Y.
  3. ny < 0: bird_y = 0.
  4. Otherwise: bird_y = ny.
- Velocity update when staying in FLYING: vel = flap_pending ? FLAP_VEL : min(vel+GRAVITY, MAX_FALL).
- Score: a frame counter counts FLYING ticks. Every SCORE_FRAMES ticks, score increments, saturating at 255.
- FSM, CRASHED:
  - flaps are ignored;
  - a counter counts CRASH_FRAMES ticks, then the FSM goes to IDLE with bird_y = START_Y and vel = 0;
  - score holds until the next start.

## Timing
- rgb, hsync and vsync have 1-cycle latency from hpos/vpos/bg_rgb/bg_solid/hsync_in/vsync_in.
- The top level feeds all pixel-stream inputs from the same cycle.
- A flap edge reaches flap_pending 3 cycles after the pin changes. It takes effect at the next tick.
- Physics uses the hit_latch accumulated over the frame just drawn. bird_y changes only on the tick, so the sprite never tears.
- The tick is simultaneous with the last hit write: hit_latch is sampled first, then cleared.
- Reset values:
  - rgb = 0, hsync = 0, vsync = 0;
  - crashed = 0, score = 0;
  - state IDLE, bird_y = START_Y, vel = 0;
  - flap_pending, hit_latch and all counters cleared.
- Reset mid-flight overrides everything in the same cycle.

## Test plan
- Reset, then 3 frames without a flap: score=0 and crashed=0. At hpos=66, vpos=120, rgb=3'b110 one cycle later. At hpos=64, vpos=120 (transparent pixel), rgb=bg_rgb.
- Pulse flap before tick 1: tick 1 enters FLYING with bird_y=120 and vel=-6. Ticks 2-5 give bird_y = 114, 109, 105, 102.
- No further flaps: vel saturates at 7 and bird_y rises until ny>=248. Then crashed=1, bird_y=248 and the sprite is red. After 60 ticks: IDLE, bird_y=120, crashed=0, score retained.
- Drive bg_solid=1 only at hpos=64, vpos=bird_y (transparent pixel): no crash. Drive it at hpos=66: CRASHED on the next tick.
- Flap every frame: bird_y clamps at 0 with no crash. After 32 flying ticks score=1. After 8192 ticks score=255 and holds.
- Assert reset while FLYING with bird_y=50: next cycle state IDLE, bird_y=120, score=0, rgb=0.
